// File: rtl/lock_fsm.sv
// Seven-press combination lock: rising edges on b0/b1 step through CODE; unlock in S7.
// Optional LOCK_SYNC_EN: two-flop synchronizers on b0/b1 ahead of edge detection.
module lock_fsm #(
    parameter logic [6:0] CODE = 7'h6A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b0,
    input  logic       b1,
    output logic       unlock,
    output logic [2:0] state
);

    // state | meaning
    // S0    | idle, no progress
    // S1-S6 | that many correct presses entered
    // S7    | unlocked; any press relocks to S0
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    // Pad to 8 bits so every state value is a legal index.
    localparam logic [7:0] CODE_EXT = {1'b0, CODE};

    state_t state_q;
    logic   b0_in;
    logic   b1_in;
    logic   b0_q;
    logic   b1_q;
    logic   rise0;
    logic   rise1;
    logic   any_rise;
    logic   single;
    logic   code_bit;
    logic   match;

`ifdef LOCK_SYNC_EN
    logic [1:0] b0_sync;
    logic [1:0] b1_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b0_sync <= 2'b00;
            b1_sync <= 2'b00;
        end else begin
            b0_sync <= {b0_sync[0], b0};
            b1_sync <= {b1_sync[0], b1};
        end
    end

    assign b0_in = b0_sync[1];
    assign b1_in = b1_sync[1];
`else
    assign b0_in = b0;
    assign b1_in = b1;
`endif

    assign rise0    = b0_in & ~b0_q;
    assign rise1    = b1_in & ~b1_q;
    assign any_rise = rise0 | rise1;
    assign single   = rise0 ^ rise1;
    assign code_bit = CODE_EXT[state_q];
    // With a single press, rise1 identifies which button it was.
    assign match    = single & (rise1 == code_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
            unlock  <= 1'b0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
        end else begin
            b0_q <= b0_in;
            b1_q <= b1_in;
            if (state_q == S7) begin
                if (any_rise) begin
                    state_q <= S0;
                    unlock  <= 1'b0;
                end
            end else if (match) begin
                state_q <= state_t'(state_q + 3'd1);
                unlock  <= (state_q == S6);
            end else if (any_rise) begin
                state_q <= S0;
                unlock  <= 1'b0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_lock_fsm.sv
// Self-checking bench for lock_fsm: directed scenarios plus randomized presses
// compared every clock against a press-counting reference model.
module tb_lock_fsm;

    logic       clk;
    logic       rst;
    logic       b0;
    logic       b1;
    logic       unlock;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Combination for the default CODE, written as the button sequence.
    int seq [7] = '{0, 1, 0, 1, 0, 1, 1};

    // Reference model: count of correct presses, 7 = open.
    int m_count = 0;
    bit p0 = 0, p1 = 0;
    bit d0 [2] = '{0, 0};
    bit d1 [2] = '{0, 0};

    lock_fsm dut (
        .clk    (clk),
        .rst    (rst),
        .b0     (b0),
        .b1     (b1),
        .unlock (unlock),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_count = 0;
        p0 = 0;
        p1 = 0;
        d0 = '{0, 0};
        d1 = '{0, 0};
    endtask

    task automatic m_edge(input bit v0, input bit v1);
        bit e0, e1, r0, r1;
        int n;
`ifdef LOCK_SYNC_EN
        e0 = d0[1]; d0[1] = d0[0]; d0[0] = v0;
        e1 = d1[1]; d1[1] = d1[0]; d1[0] = v1;
`else
        e0 = v0;
        e1 = v1;
`endif
        r0 = e0 && !p0;
        r1 = e1 && !p1;
        p0 = e0;
        p1 = e1;
        n  = int'(r0) + int'(r1);
        if (m_count == 7) begin
            if (n != 0) m_count = 0;
        end else if (n == 2) begin
            m_count = 0;
        end else if (n == 1) begin
            m_count = ((r1 ? 1 : 0) == seq[m_count]) ? m_count + 1 : 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset();
        end else begin
            m_edge(b0, b1);
            #1;
            check("state", int'(state), m_count);
            check("unlock", int'(unlock), (m_count == 7) ? 1 : 0);
        end
    end

    task automatic set(input bit v0, input bit v1);
        @(negedge clk);
        b0 = v0;
        b1 = v1;
    endtask

    task automatic idle(input int n);
        repeat (n) set(0, 0);
    endtask

    task automatic press(input int btn);
        set(btn == 0, btn == 1);
        set(0, 0);
    endtask

    task automatic enter_prefix(input int n);
        for (int i = 0; i < n; i++) press(seq[i]);
        idle(3);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_unlock", int'(unlock), 0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int r;
        rst = 1'b0;
        b0  = 1'b0;
        b1  = 1'b0;
        #8;
        check("por_state", int'(state), 0);
        check("por_unlock", int'(unlock), 0);
        #5;
        rst = 1'b1;
        idle(3);
        check("idle_state", int'(state), 0);

        // Correct code, then relock with b1.
        enter_prefix(7);
        check("open_state", int'(state), 7);
        check("open_unlock", int'(unlock), 1);
        press(1);
        idle(3);
        check("relock_state", int'(state), 0);
        check("relock_unlock", int'(unlock), 0);

        // Wrong third press, then full code.
        press(0); press(1); press(1);
        idle(3);
        check("wrong_state", int'(state), 0);
        check("wrong_unlock", int'(unlock), 0);
        enter_prefix(7);
        check("retry_state", int'(state), 7);
        press(0);
        idle(3);

        // Held button counts once.
        repeat (5) set(1, 0);
        idle(3);
        check("hold_state", int'(state), 1);

        // Both buttons from S3.
        press(1); press(0);
        idle(3);
        check("s3_state", int'(state), 3);
        set(1, 1);
        idle(4);
        check("both_state", int'(state), 0);

        // Asynchronous reset from S5.
        enter_prefix(5);
        check("s5_state", int'(state), 5);
        pulse_rst();
        idle(3);

        // Button held through reset release registers as a press.
        set(1, 0);
        pulse_rst();
        set(0, 0);
        idle(3);
        check("held_rst_state", int'(state), 1);
        pulse_rst();
        idle(3);

        // Randomized presses checked each edge by the monitor.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                set(0, 0);
            end else if (r < 70) begin
                if (m_count < 7) set(seq[m_count] == 0, seq[m_count] == 1);
                else set($urandom_range(0, 1) == 0, 0);
            end else if (r < 80) begin
                if (m_count < 7) set(seq[m_count] == 1, seq[m_count] == 0);
                else set(0, 1);
            end else if (r < 88) begin
                set(1, 1);
            end else if (r < 98) begin
                set(b0, b1);
            end else begin
                set($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                pulse_rst();
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lock_fsm.md
# lock_fsm

Seven-press combination lock finite-state machine driven by two push-button inputs. It detects rising edges on `b0` and `b1`, advances one state per correct press, and asserts `unlock` after the full sequence is entered. The block is a self-contained leaf for front-panel access control. It exposes its state register for debug and status display.

## Interface
Parameters:
- `CODE`, default 7'h6A. Combination; bit i is the button for press i+1 (0 = `b0`, 1 = `b1`). The default sequence is b0,b1,b0,b1,b0,b1,b1.

Ports:
- `clk`  input  1  System clock; all state changes on its rising edge.
- `rst`  input  1  Asynchronous, active-low reset.
- `b0`  input  1  Button 0 level; high = pressed.
- `b1`  input  1  Button 1 level; high = pressed.
- `unlock`  output  1  High while in the unlocked state (S7). Registered Moore output.
- `state`  output  3  Current state index, 0–7.

## Operation
- Edge detect:
  - Registers `b0_q` and `b1_q` hold each button's value from the previous clock edge.
  - A press of bX is `bX & ~bX_q`.
  - A held button counts as exactly one press.
- Press classification on each edge:
  - **none**: no rising edge.
  - **single**: exactly one button rising. A rising edge on one button while the other is held counts as single.
  - **both**: both buttons rising on the same edge.
- States:
  - S0 = idle.
  - Sk (k = 1..6) = k correct presses entered.
  - S7 = unlocked.
- Transitions from Sk, k = 0..6:
  - none: stay in Sk.
  - single press matching `CODE[k]`: go to Sk+1.
  - single press not matching, or both: go to S0. The wrong press is consumed; it does not restart at S1.
- Transitions from S7:
  - Hold S7 while there are no presses.
  - Any press (single or both): go to S0 (relock).
- Outputs:
  - `state` = state register.
  - `unlock` = 1 exactly when state == 7. `unlock` is registered alongside `state`, with no combinational glitch.
- Reset (`rst` low, asynchronous):
  - state = 0, `unlock` = 0, `b0_q` = `b1_q` = 0.
  - A button held high when `rst` releases registers as a press on the first clock edge.
  - Reset asserted mid-sequence discards all progress immediately, without waiting for a clock edge.

## Timing
- Latency: a button first sampled high at edge N updates `state`/`unlock` at edge N.
  - Visible after edge N; zero added cycles.
  - With `LOCK_SYNC_EN`, the update is at edge N+2.
- Pulses shorter than one clock period that miss every rising edge are ignored.
- A pulse must be low for at least one sampled edge between presses to count twice.
- Exactly one state transition per clock edge.

## Configuration
- `LOCK_SYNC_EN` defined:
  - `b0`/`b1` each pass through a two-flop synchronizer before edge detection.
  - Synchronizer flops reset to 0.
  - Adds 2 cycles of press-to-state latency.
- Not defined:
  - Buttons feed edge detection directly.
  - Inputs must already be synchronous to `clk`.

## Test plan
- Reset: drive `rst` low with buttons idle -> `state` = 0 and `unlock` = 0 immediately; both remain after `rst` returns high.
- Correct code: single-cycle presses b0,b1,b0,b1,b0,b1,b1, each separated by one low cycle -> `state` steps 1..7; `unlock` = 1 only after the 7th press.
- Wrong press: b0,b1,b1 -> `state` 1,2,0; `unlock` stays 0. The full correct sequence afterwards reaches 7.
- Hold and simultaneity:
  - b0 held for 5 cycles -> `state` = 1, advancing once only.
  - b0 and b1 rising on the same edge from S3 -> `state` = 0.
- Relock and async reset:
  - From S7, press b1 -> `state` = 0, `unlock` = 0.
  - From S5, pulse `rst` low between clock edges -> `state` = 0 before the next edge.
- With `LOCK_SYNC_EN`: repeat the correct-code scenario -> `state` changes 2 edges after each press is first sampled; final `unlock` = 1.
